// File: rtl/peak_scan_ctrl.sv
// Per-line peak scan sequencer wrapped around max_finder: clear, sync, window gate, drain, hold.
// Optional watchdog on WAIT_SYNC/SCAN is enabled by defining PEAK_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for trig; config registers hold last scan's window
// CLEAR     | mf_start held high for START_CYC cycles to clear max_finder
// WAIT_SYNC | waiting for line_sync to restart the pixel index
// SCAN      | counting valid pixels, gating in-window pixels to max_finder
// DRAIN     | MF_LAT cycles for max_finder to absorb the last gated pixel
// HOLD      | result presented with res_valid until res_ack
module peak_scan_ctrl #(
    parameter int START_CYC   = 2,
    parameter int MF_LAT      = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       trig,
    input  logic       line_sync,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    input  logic [8:0] win_start,
    input  logic [8:0] win_end,
    input  logic [7:0] min_peak,
    output logic       mf_start,
    output logic       mf_data_valid,
    output logic [7:0] mf_data_in,
    output logic [8:0] mf_data_pos,
    input  logic [8:0] mf_max_pos,
    input  logic [7:0] mf_max_value,
    output logic       busy,
    output logic       err_cfg,
    output logic       res_valid,
    input  logic       res_ack,
    output logic [8:0] res_pos,
    output logic [7:0] res_value,
    output logic [2:0] res_flags
);

    if (START_CYC < 1 || START_CYC > 7 || MF_LAT < 1 || MF_LAT > 7 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("peak_scan_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_SYNC, SCAN, DRAIN, HOLD} state_t;

    state_t     state_q, state_d;
    logic [8:0] win_start_q, win_end_q;
    logic [7:0] min_peak_q;
    logic [2:0] cnt_q;
    logic [8:0] idx_q;
    logic       trunc_q;
    logic       cfg_ok, in_win, cnt_done, last_pix, timeout_hit;

    assign cfg_ok   = trig && (win_start <= win_end);
    assign in_win   = (idx_q >= win_start_q) && (idx_q <= win_end_q);
    assign cnt_done = (cnt_q == 3'd0);
    assign last_pix = (idx_q == win_end_q) || (idx_q == 9'd511);

`ifdef PEAK_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wdog_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (state_q == IDLE && cfg_ok) begin
            wdog_q <= '0;
        end else if (state_q == WAIT_SYNC || state_q == SCAN) begin
            wdog_q <= wdog_q + 16'd1;
        end
    end

    assign timeout_hit = (state_q == WAIT_SYNC || state_q == SCAN) && (wdog_q == WDOG_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mf_start  = (state_q == CLEAR);
        busy      = (state_q != IDLE);
        res_valid = (state_q == HOLD);
        case (state_q)
            IDLE:      if (cfg_ok) state_d = CLEAR;
            CLEAR:     if (cnt_done) state_d = WAIT_SYNC;
            WAIT_SYNC: begin
                if (timeout_hit)    state_d = HOLD;
                else if (line_sync) state_d = SCAN;
            end
            SCAN: begin
                if (timeout_hit)                state_d = HOLD;
                else if (line_sync)             state_d = DRAIN;
                else if (pix_valid && last_pix) state_d = DRAIN;
            end
            DRAIN:     if (cnt_done) state_d = HOLD;
            HOLD:      if (res_ack) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            win_start_q   <= '0;
            win_end_q     <= '0;
            min_peak_q    <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            trunc_q       <= 1'b0;
            err_cfg       <= 1'b0;
            mf_data_valid <= 1'b0;
            mf_data_in    <= '0;
            mf_data_pos   <= '0;
            res_pos       <= '0;
            res_value     <= '0;
            res_flags     <= '0;
        end else begin
            err_cfg       <= (state_q == IDLE) && trig && !cfg_ok;
            mf_data_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_ok) begin
                        win_start_q <= win_start;
                        win_end_q   <= win_end;
                        min_peak_q  <= min_peak;
                        cnt_q       <= 3'(START_CYC - 1);
                        trunc_q     <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (!cnt_done) cnt_q <= cnt_q - 3'd1;
                end
                WAIT_SYNC, SCAN: begin
                    if (timeout_hit) begin
                        res_pos   <= '0;
                        res_value <= '0;
                        res_flags <= 3'b100;
                    end else if (line_sync) begin
                        // In WAIT_SYNC this starts the line; in SCAN it cuts the line short
                        if (state_q == WAIT_SYNC) begin
                            idx_q <= '0;
                        end else begin
                            trunc_q <= 1'b1;
                            cnt_q   <= 3'(MF_LAT - 1);
                        end
                    end else if (state_q == SCAN && pix_valid) begin
                        if (in_win) begin
                            mf_data_valid <= 1'b1;
                            mf_data_in    <= pix_data;
                            mf_data_pos   <= idx_q;
                        end
                        if (idx_q != 9'd511) idx_q <= idx_q + 9'd1;
                        if (last_pix) begin
                            cnt_q <= 3'(MF_LAT - 1);
                            if (idx_q != win_end_q) trunc_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_done) begin
                        res_pos   <= mf_max_pos;
                        res_value <= mf_max_value;
                        res_flags <= {1'b0, trunc_q, (mf_max_value < min_peak_q)};
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Directed bench for peak_scan_ctrl with a behavioural max_finder and a result scoreboard.
module tb_peak_scan_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       trig = 1'b0, line_sync = 1'b0, pix_valid = 1'b0, res_ack = 1'b0;
    logic [7:0] pix_data = '0, min_peak = '0;
    logic [8:0] win_start = '0, win_end = '0;
    logic       mf_start, mf_data_valid, busy, err_cfg, res_valid;
    logic [7:0] mf_data_in, mf_max_value, res_value;
    logic [8:0] mf_data_pos, mf_max_pos, res_pos;
    logic [2:0] res_flags;

    always #5 clk_in = ~clk_in;

    peak_scan_ctrl #(.START_CYC(2), .MF_LAT(2), .TIMEOUT_CYC(1000)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .trig(trig), .line_sync(line_sync),
        .pix_valid(pix_valid), .pix_data(pix_data), .win_start(win_start),
        .win_end(win_end), .min_peak(min_peak), .mf_start(mf_start),
        .mf_data_valid(mf_data_valid), .mf_data_in(mf_data_in),
        .mf_data_pos(mf_data_pos), .mf_max_pos(mf_max_pos),
        .mf_max_value(mf_max_value), .busy(busy), .err_cfg(err_cfg),
        .res_valid(res_valid), .res_ack(res_ack), .res_pos(res_pos),
        .res_value(res_value), .res_flags(res_flags)
    );

    // Behavioural max_finder: one-cycle registered running maximum, first maximum wins
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mf_max_pos   <= '0;
            mf_max_value <= '0;
        end else if (mf_start) begin
            mf_max_pos   <= '0;
            mf_max_value <= '0;
        end else if (mf_data_valid && mf_data_in > mf_max_value) begin
            mf_max_pos   <= mf_data_pos;
            mf_max_value <= mf_data_in;
        end
    end

    typedef struct {
        int pos;
        int value;
        int flags;
        int pulses;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    int   pulse_cnt = 0;
    logic rv_prev   = 1'b0;
    exp_t mon_e;

    always @(negedge clk_in) begin
        if (!rst_n) begin
            pulse_cnt = 0;
            rv_prev   = 1'b0;
        end else begin
            if (mf_start) pulse_cnt = 0;
            else if (mf_data_valid) pulse_cnt++;
            if (res_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got res_pos %0d with no expectation queued", res_pos);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_pos",   32'(res_pos),   mon_e.pos);
                    check("res_value", 32'(res_value), mon_e.value);
                    check("res_flags", 32'(res_flags), mon_e.flags);
                    check("mf_pulses", pulse_cnt,      mon_e.pulses);
                end
            end
            rv_prev = res_valid;
        end
    end

    function automatic logic [7:0] pix_val(input int pat, input int idx);
        if (pat == 0) begin
            if (idx == 123) return 8'd100;
            if (idx == 130) return 8'd110;
            if (idx == 140) return 8'd90;
            return 8'd10;
        end
        return (idx == 5) ? 8'd77 : 8'd200;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // trig, a line_sync during CLEAR that must be ignored, then the real line_sync
    task automatic start_scan(input logic [8:0] ws, input logic [8:0] we, input logic [7:0] mp);
        trig = 1'b1; win_start = ws; win_end = we; min_peak = mp;
        tick();
        trig = 1'b0; win_start = 9'd0; win_end = 9'd511; min_peak = 8'd255;
        line_sync = 1'b1;
        tick();
        line_sync = 1'b0;
        repeat (3) tick();
        line_sync = 1'b1;
        tick();
        line_sync = 1'b0;
    endtask

    task automatic drive_pixels(input int pat, input int n, input int sync_at);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = pix_val(pat, i);
            if (i == sync_at) begin
                line_sync = 1'b1;
                pix_data  = 8'd200;
            end
            tick();
            line_sync = 1'b0;
            if (i == sync_at) break;
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!res_valid && n < 3000) begin
            tick();
            n++;
        end
        if (!res_valid) begin
            tests++;
            fails++;
            $display("FAIL wait_res_valid: got res_valid 0 expected 1 within 3000 cycles");
        end
    endtask

    task automatic hold_and_ack(input int ep, input int ev, input int ef, input int delay, input bit poke);
        for (int i = 0; i < delay; i++) begin
            check("hold_res_valid", 32'(res_valid), 1);
            check("hold_res_pos",   32'(res_pos),   ep);
            check("hold_res_value", 32'(res_value), ev);
            check("hold_res_flags", 32'(res_flags), ef);
            trig = poke && (i == delay / 2);
            win_start = 9'd0; win_end = 9'd10;
            tick();
        end
        trig = 1'b0;
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("ack_res_valid", 32'(res_valid), 0);
        check("ack_busy",      32'(busy),      0);
        repeat (3) tick();
        check("idle_mf_start", 32'(mf_start),  0);
        check("idle_busy",     32'(busy),      0);
        check("idle_res_pos",  32'(res_pos),   ep);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 1ms");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int errs;
        int cyc;

        repeat (3) tick();
        check("rst_busy",      32'(busy),          0);
        check("rst_mf_start",  32'(mf_start),      0);
        check("rst_mf_valid",  32'(mf_data_valid), 0);
        check("rst_res_valid", 32'(res_valid),     0);
        check("rst_res_flags", 32'(res_flags),     0);
        rst_n = 1'b1;
        tick();

        // Normal scan, window 100..200
        exp_q.push_back('{130, 110, 0, 101});
        start_scan(9'd100, 9'd200, 8'd50);
        drive_pixels(0, 301, -1);
        wait_result();
        hold_and_ack(130, 110, 0, 2, 1'b0);

        // Same line, weak peak
        exp_q.push_back('{130, 110, 1, 101});
        start_scan(9'd100, 9'd200, 8'd120);
        drive_pixels(0, 301, -1);
        wait_result();
        hold_and_ack(130, 110, 1, 2, 1'b0);

        // Truncated by line_sync at idx 250; bright pixel in that cycle must not be gated
        exp_q.push_back('{130, 110, 2, 150});
        start_scan(9'd100, 9'd400, 8'd50);
        drive_pixels(0, 400, 250);
        wait_result();
        hold_and_ack(130, 110, 2, 50, 1'b1);

        // Single-pixel window, peak equal to min_peak qualifies
        exp_q.push_back('{5, 77, 0, 1});
        start_scan(9'd5, 9'd5, 8'd77);
        drive_pixels(1, 20, -1);
        wait_result();
        hold_and_ack(5, 77, 0, 3, 1'b0);

        // Reversed window rejected
        trig = 1'b1; win_start = 9'd300; win_end = 9'd200;
        tick();
        trig = 1'b0;
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            errs += int'(err_cfg);
            check("cfgerr_busy",     32'(busy),     0);
            check("cfgerr_mf_start", 32'(mf_start), 0);
            tick();
        end
        check("cfgerr_pulses", errs, 1);

`ifdef PEAK_TIMEOUT_EN
        // Watchdog: no line_sync after CLEAR
        exp_q.push_back('{0, 0, 4, 0});
        trig = 1'b1; win_start = 9'd10; win_end = 9'd20; min_peak = 8'd0;
        tick();
        trig = 1'b0;
        cyc = 0;
        while (mf_start && cyc < 20) begin
            tick();
            cyc++;
        end
        cyc = 0;
        while (!res_valid && cyc < 1100) begin
            tick();
            cyc++;
        end
        check("timeout_cycles", cyc, 1000);
        hold_and_ack(0, 0, 4, 2, 1'b0);
`endif

        // Asynchronous reset in the middle of SCAN
        start_scan(9'd0, 9'd300, 8'd0);
        drive_pixels(0, 40, -1);
        check("pre_rst_busy",     32'(busy),          1);
        check("pre_rst_mf_valid", 32'(mf_data_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",      32'(busy),          0);
        check("arst_mf_valid",  32'(mf_data_valid), 0);
        check("arst_mf_data",   32'(mf_data_in),    0);
        check("arst_mf_pos",    32'(mf_data_pos),   0);
        check("arst_mf_start",  32'(mf_start),      0);
        check("arst_err_cfg",   32'(err_cfg),       0);
        check("arst_res_valid", 32'(res_valid),     0);
        check("arst_res_pos",   32'(res_pos),       0);
        check("arst_res_value", 32'(res_value),     0);
        check("arst_res_flags", 32'(res_flags),     0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_busy", 32'(busy), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
